ex_divider: RTL and testbench



---
 rtl/ex_divider.sv | 171 +++++++++++++++++
 tb/tb_ex_divider.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ex_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} and holds the pipeline via stall_request while busy.
module ex_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      cancel,
  input  logic                      signed_div,
  input  logic [DATA_WIDTH-1:0]     dividend,
  input  logic [DATA_WIDTH-1:0]     divisor,
  output logic [2*DATA_WIDTH-1:0]   result,
  output logic                      ready,
  output logic                      stall_request
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] W_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DIV_BY_ZERO = 2'd1,
    RUNNING     = 2'd2,
    DONE        = 2'd3
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic [DATA_WIDTH-1:0] v,
                                                     input logic en);
    if (en) begin
      cond_neg = ~v + W_ONE;
    end else begin
      cond_neg = v;
    end
  endfunction

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DATA_WIDTH-1:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   quo_q, quo_d;
  logic [DATA_WIDTH-1:0]   dvs_q, dvs_d;
  logic                    q_neg_q, q_neg_d;
  logic                    r_neg_q, r_neg_d;
  logic [2*DATA_WIDTH-1:0] result_q, result_d;
  logic                    ready_q, ready_d;

  logic [DATA_WIDTH:0]     shifted_s;
  logic [DATA_WIDTH-1:0]   diff_s;
  logic                    qbit_s;
  logic [DATA_WIDTH-1:0]   rem_next_s;
  logic [DATA_WIDTH-1:0]   quo_next_s;

  // One restoring step: the W+1-bit compare is the trial subtract; only the low W
  // bits of the difference survive since a kept remainder is always below the divisor.
  always_comb begin
    shifted_s  = {rem_q, quo_q[DATA_WIDTH-1]};
    qbit_s     = (shifted_s >= {1'b0, dvs_q});
    diff_s     = shifted_s[DATA_WIDTH-1:0] - dvs_q;
    rem_next_s = qbit_s ? diff_s : shifted_s[DATA_WIDTH-1:0];
    quo_next_s = {quo_q[DATA_WIDTH-2:0], qbit_s};
  end

  // Next-state, datapath loads and stall request.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    q_neg_d       = q_neg_q;
    r_neg_d       = r_neg_q;
    result_d      = result_q;
    ready_d       = ready_q;
    stall_request = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          stall_request = 1'b1;
          if (divisor == {DATA_WIDTH{1'b0}}) begin
            state_d = DIV_BY_ZERO;
          end else begin
            quo_d   = cond_neg(dividend, signed_div & dividend[DATA_WIDTH-1]);
            dvs_d   = cond_neg(divisor, signed_div & divisor[DATA_WIDTH-1]);
            q_neg_d = signed_div & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
            r_neg_d = signed_div & dividend[DATA_WIDTH-1];
            rem_d   = {DATA_WIDTH{1'b0}};
            count_d = {CNT_W{1'b0}};
            state_d = RUNNING;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DIV_BY_ZERO: begin
        stall_request = 1'b1;
        if (cancel) begin
          state_d = IDLE;
        end else begin
          result_d = {(2*DATA_WIDTH){1'b0}};
          ready_d  = 1'b1;
          state_d  = DONE;
        end
      end
      RUNNING: begin
        stall_request = 1'b1;
        // Cancel wins even over the final iteration; nothing is committed.
        if (cancel) begin
          count_d = {CNT_W{1'b0}};
          ready_d = 1'b0;
          state_d = IDLE;
        end else begin
          rem_d   = rem_next_s;
          quo_d   = quo_next_s;
          count_d = count_q + CNT_ONE;
          if (count_q == CNT_LAST) begin
            result_d = {cond_neg(rem_next_s, r_neg_q), cond_neg(quo_next_s, q_neg_q)};
            ready_d  = 1'b1;
            state_d  = DONE;
          end else begin
            state_d = RUNNING;
          end
        end
      end
      DONE: begin
        if (!start) begin
          result_d = {(2*DATA_WIDTH){1'b0}};
          ready_d  = 1'b0;
          state_d  = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        result_d = {(2*DATA_WIDTH){1'b0}};
        ready_d  = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= {CNT_W{1'b0}};
      rem_q    <= {DATA_WIDTH{1'b0}};
      quo_q    <= {DATA_WIDTH{1'b0}};
      dvs_q    <= {DATA_WIDTH{1'b0}};
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= {(2*DATA_WIDTH){1'b0}};
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_ex_divider.sv
// Directed self-checking bench for ex_divider: arithmetic corners, latency,
// cancel, divide-by-zero and asynchronous reset.
module tb_ex_divider;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        cancel;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [63:0] result;
  logic        ready;
  logic        stall_request;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  ex_divider #(.DATA_WIDTH(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .cancel        (cancel),
    .signed_div    (signed_div),
    .dividend      (dividend),
    .divisor       (divisor),
    .result        (result),
    .ready         (ready),
    .stall_request (stall_request)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one divide with start held, tamper with operands after capture,
  // measure latency and stall cycles, confirm cancel is ignored in DONE, then release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    int edges;
    int stalls;
    logic [63:0] held;
    signed_div = sgn;
    dividend   = a;
    divisor    = b;
    cancel     = 1'b0;
    start      = 1'b1;
    edges      = 0;
    stalls     = 0;
    #1;
    while (!ready && edges < 40) begin
      if (stall_request) stalls++;
      @(negedge clock);
      edges++;
      if (edges == 1) begin
        dividend = ~a;
        divisor  = b + 32'd1;
      end
    end
    check({tag, " latency"}, 64'(edges), 64'(exp_lat));
    check({tag, " stall_cycles"}, 64'(stalls), 64'(exp_lat));
    check({tag, " result"}, result, exp_res);
    check({tag, " stall_in_done"}, 64'(stall_request), 64'd0);
    held   = result;
    cancel = 1'b1;
    @(negedge clock);
    check({tag, " done_ready_hold"}, 64'(ready), 64'd1);
    check({tag, " done_result_hold"}, result, held);
    cancel = 1'b0;
    start  = 1'b0;
    @(negedge clock);
    check({tag, " release_ready"}, 64'(ready), 64'd0);
    check({tag, " release_result"}, result, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_ready;
    reset      = 1'b0;
    start      = 1'b0;
    cancel     = 1'b0;
    signed_div = 1'b0;
    dividend   = 32'd0;
    divisor    = 32'd0;
    repeat (2) @(negedge clock);
    check("reset ready", 64'(ready), 64'd0);
    check("reset result", result, 64'd0);
    check("reset stall", 64'(stall_request), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    run_div("udiv 100/7",      1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33);
    run_div("sdiv -7/2",       1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 33);
    run_div("sdiv 7/-2",       1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33);
    run_div("udiv fff9/2",     1'b0, 32'hFFFFFFF9,   32'h00000002,   64'h00000001_7FFFFFFC, 33);
    run_div("sdiv by zero",    1'b1, 32'h12345678,   32'h00000000,   64'h00000000_00000000, 2);
    run_div("udiv by zero",    1'b0, 32'h12345678,   32'h00000000,   64'h00000000_00000000, 2);
    run_div("sdiv min/-1",     1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33);
    run_div("udiv max/1",      1'b0, 32'hFFFFFFFF,   32'h00000001,   64'h00000000_FFFFFFFF, 33);

    // Cancel ten cycles into a divide.
    signed_div = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    start      = 1'b1;
    repeat (10) @(negedge clock);
    cancel = 1'b1;
    start  = 1'b0;
    #1;
    check("cancel stall_before", 64'(stall_request), 64'd1);
    @(negedge clock);
    cancel = 1'b0;
    check("cancel stall_after", 64'(stall_request), 64'd0);
    check("cancel ready", 64'(ready), 64'd0);
    check("cancel result", result, 64'd0);
    saw_ready = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (ready) saw_ready = 1'b1;
    end
    check("cancel no_ready", 64'(saw_ready), 64'd0);
    run_div("udiv 9/3 after cancel", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // Asynchronous reset in the middle of RUNNING.
    signed_div = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    start      = 1'b1;
    repeat (15) @(negedge clock);
    start = 1'b0;
    #1;
    check("midrun stall_before", 64'(stall_request), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midrun reset stall", 64'(stall_request), 64'd0);
    check("midrun reset ready", 64'(ready), 64'd0);
    check("midrun reset result", result, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_div("udiv 100/7 after reset", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

    // Asynchronous reset while a result is held in DONE.
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    repeat (34) @(negedge clock);
    check("done pre_reset ready", 64'(ready), 64'd1);
    check("done pre_reset result", result, 64'h00000002_0000000E);
    #2;
    reset = 1'b0;
    #1;
    check("done reset ready", 64'(ready), 64'd0);
    check("done reset result", result, 64'd0);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
